// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel stage.
// Two cascaded line buffers supply the two previous rows; three 2-deep
// column tap shift registers hold the older columns of each window row.
module sobel_window_gen #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     pixel_in,
  input  logic                  pixel_valid,
  input  logic                  frame_start,
  output logic [9*DATA_W-1:0]   window,
  output logic                  window_valid,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic                frame_over;

  logic [DATA_W-1:0]   lb1 [IMG_WIDTH];
  logic [DATA_W-1:0]   lb2 [IMG_WIDTH];

  // Older two columns per window row; upper half is the oldest column.
  logic [2*DATA_W-1:0] tap0, tap1, tap2;

  logic [CW-1:0]       cur_col;
  logic [RW-1:0]       cur_row;
  logic                accept;
  logic                last_col, last_row;
  logic                win_ok;
  logic [DATA_W-1:0]   rd1, rd2;

  // Effective position of the incoming pixel and qualification of the accept.
  always_comb begin
    cur_col  = frame_start ? '0 : col;
    cur_row  = frame_start ? '0 : row;
    // Once the last pixel of a frame is taken, only frame_start reopens input.
    accept   = pixel_valid & (frame_start | ~frame_over);
    last_col = (cur_col == COL_LAST);
    last_row = (cur_row == ROW_LAST);
    win_ok   = accept & (cur_row >= RW'(2)) & (cur_col >= CW'(2));
    rd1      = lb1[cur_col];
    rd2      = lb2[cur_col];
  end

  // Line buffers: line-1 data cascades into the line-2 buffer at the same column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= pixel_in;
      lb2[cur_col] <= rd1;
    end
  end

  // Raster position counters; row saturates at the last line until frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      frame_over <= 1'b0;
    end else if (accept) begin
      col        <= last_col ? '0 : cur_col + CW'(1);
      row        <= (last_col && !last_row) ? cur_row + RW'(1) : cur_row;
      frame_over <= last_col & last_row;
    end
  end

  // Column tap shift registers for the three window rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap0 <= '0;
      tap1 <= '0;
      tap2 <= '0;
    end else if (accept) begin
      tap0 <= {tap0[DATA_W-1:0], rd2};
      tap1 <= {tap1[DATA_W-1:0], rd1};
      tap2 <= {tap2[DATA_W-1:0], pixel_in};
    end
  end

  // Registered window output; holds its value between valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window       <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= win_ok;
      frame_done   <= win_ok & last_col & last_row;
      if (win_ok) begin
        window <= {tap0, rd2, tap1, rd1, tap2, pixel_in};
      end
    end
  end

endmodule
